// File: rtl/restoring_divider_if.sv
// Handshake bundle for restoring_divider.
//   Request side : in_valid/in_ready with dividend r (2N bits) and divisor v (N bits).
//   Response side: out_valid/out_ready with quotient q (2N bits), remainder m (N bits)
//                  and divide-by-zero flag dz.
// The slave modport is the divider's view; master is the producer/consumer view.
interface restoring_divider_if #(
  parameter int N = 16
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] r;
  logic [N-1:0]   v;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] q;
  logic [N-1:0]   m;
  logic           dz;

  modport master (
    output in_valid, r, v, out_ready,
    input  in_ready, out_valid, q, m, dz
  );

  modport slave (
    input  in_valid, r, v, out_ready,
    output in_ready, out_valid, q, m, dz
  );
endinterface

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: r (2N bits) / v (N bits) gives
// q (2N bits) and m (N bits) with r = q*v + m, m < v. One quotient bit per clock.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - restoring_divider_if.slave: in_valid/in_ready/r/v request handshake,
//          out_valid/out_ready/q/m/dz response handshake. All outputs registered.
module restoring_divider #(
  parameter int N = 16
) (
  input  logic               clk,
  input  logic               rst,
  restoring_divider_if.slave bus
);

  localparam int CW = $clog2(2*N+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [2*N-1:0] quot;      // dividend shifts out of the MSB, quotient bits enter the LSB
  logic [N-1:0]   divisor;
  logic [N-1:0]   rem;       // partial remainder; always < divisor so N bits hold it
  logic [CW-1:0]  cnt;
  logic           in_ready_r;
  logic           out_valid_r;
  logic [2*N-1:0] q_r;
  logic [N-1:0]   m_r;
  logic           dz_r;

  logic [N:0]     p;
  logic [N:0]     sub;
  logic           ge;
  logic [N-1:0]   rem_nxt;
  logic [2*N-1:0] quot_nxt;

  // Iteration datapath. Since p < 2*divisor, p - divisor either fits in N bits
  // (no borrow) or wraps negative with the top bit set, so the borrow bit alone
  // decides whether the subtraction is kept.
  always_comb begin
    p        = {rem, quot[2*N-1]};
    sub      = p - {1'b0, divisor};
    ge       = ~sub[N];
    rem_nxt  = ge ? sub[N-1:0] : p[N-1:0];
    quot_nxt = {quot[2*N-2:0], ge};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      quot        <= '0;
      divisor     <= '0;
      rem         <= '0;
      cnt         <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      q_r         <= '0;
      m_r         <= '0;
      dz_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            quot       <= bus.r;
            divisor    <= bus.v;
            rem        <= '0;
            cnt        <= CW'(2*N);
            in_ready_r <= 1'b0;
            if (bus.v == '0) begin
              q_r         <= '1;
              m_r         <= bus.r[N-1:0];
              dz_r        <= 1'b1;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end

        CALC: begin
          quot <= quot_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt - CW'(1);
          // Last iteration: publish the result directly from the next-state values.
          if (cnt == CW'(1)) begin
            q_r         <= quot_nxt;
            m_r         <= rem_nxt;
            dz_r        <= 1'b0;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.q         = q_r;
  assign bus.m         = m_r;
  assign bus.dz        = dz_r;

endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider (N=16): directed vectors plus a random regression.
// Expected responses are queued when an operation is accepted; a monitor pops and
// compares whenever the divider completes a result handshake.
module tb_restoring_divider;

  localparam int N = 16;

  logic clk;
  logic rst;

  restoring_divider_if #(.N(N)) bus ();

  restoring_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          exact;
    logic [31:0] r;
    logic [15:0] v;
    logic [31:0] q;
    logic [15:0] m;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int tests;
  int errors;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference product q*v built from three half-width products.
  function automatic logic [63:0] kmul(input logic [31:0] a, input logic [31:0] b);
    logic [15:0] a1, a0, b1, b0;
    logic [31:0] z2, z0;
    logic [16:0] sa, sbb;
    logic [33:0] z1;
    a1  = a[31:16];
    a0  = a[15:0];
    b1  = b[31:16];
    b0  = b[15:0];
    z2  = a1 * b1;
    z0  = a0 * b0;
    sa  = {1'b0, a1} + {1'b0, a0};
    sbb = {1'b0, b1} + {1'b0, b0};
    z1  = 34'(sa) * 34'(sbb) - 34'(z2) - 34'(z0);
    return (64'(z2) << 32) + (64'(z1) << 16) + 64'(z0);
  endfunction

  // Result monitor: a handshake happens at the next rising edge when both are high here.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_result: got q=%0h m=%0h, required no result", bus.q, bus.m);
        end else begin
          e = sb.pop_front();
          if (e.exact) begin
            check({e.name, "_q"},  64'(bus.q),  64'(e.q));
            check({e.name, "_m"},  64'(bus.m),  64'(e.m));
            check({e.name, "_dz"}, 64'(bus.dz), 64'(e.dz));
          end else begin
            tests++;
            if ((kmul(bus.q, 32'(e.v)) + 64'(bus.m)) !== 64'(e.r) || bus.m >= e.v || bus.dz !== 1'b0) begin
              errors++;
              $display("FAIL %s: r=%0h v=%0h got q=%0h m=%0h dz=%b, required q*v+m==r, m<v, dz=0",
                       e.name, e.r, e.v, bus.q, bus.m, bus.dz);
            end
          end
        end
      end
    end
  end

  // Present an operation and wait (bounded) until it is accepted; returns at accept edge + 1.
  task automatic send(input string name, input bit exact, input logic [31:0] rr, input logic [15:0] vv,
                      input logic [31:0] eq, input logic [15:0] em, input logic edz);
    exp_t e;
    int guard;
    guard = 0;
    bus.r = rr;
    bus.v = vv;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      tests++;
      errors++;
      $display("FAIL %s_accept: in_ready stayed %b, required 1", name, bus.in_ready);
    end else begin
      e.name = name; e.exact = exact; e.r = rr; e.v = vv; e.q = eq; e.m = em; e.dz = edz;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) begin
      tests++;
      errors++;
      $display("FAIL %s_drain: %0d results outstanding, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time exceeded, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tests = 0;
    errors = 0;
    bus.in_valid = 1'b0;
    bus.r = '0;
    bus.v = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  64'(bus.in_ready),  64'd1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_q",         64'(bus.q),         64'd0);
    check("reset_m",         64'(bus.m),         64'd0);
    check("reset_dz",        64'(bus.dz),        64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic divide with latency measurement.
    send("basic", 1'b1, 32'd1000, 16'd7, 32'd142, 16'd6, 1'b0);
    check("basic_in_ready_drop", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("basic_latency_edges", 64'(lat), 64'd32);
    wait_drain("basic");

    send("full_ffff", 1'b1, 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0);
    wait_drain("full_ffff");
    send("full_one", 1'b1, 32'hFFFF_FFFF, 16'h0001, 32'hFFFF_FFFF, 16'h0000, 1'b0);
    wait_drain("full_one");
    send("small", 1'b1, 32'd5, 16'd9, 32'd0, 16'd5, 1'b0);
    wait_drain("small");

    // Divide by zero: result is up right after the accept edge.
    bus.out_ready = 1'b0;
    send("divzero", 1'b1, 32'h1234_5678, 16'h0000, 32'hFFFF_FFFF, 16'h5678, 1'b1);
    check("divzero_valid_next_cycle", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    wait_drain("divzero");

    // Backpressure, with ignored request traffic while busy.
    bus.out_ready = 1'b0;
    send("bp", 1'b1, 32'd1000, 16'd7, 32'd142, 16'd6, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = i[0];
      bus.r = $urandom;
      bus.v = 16'd3;
    end
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_hold_valid",    64'(bus.out_valid), 64'd1);
      check("bp_hold_in_ready", 64'(bus.in_ready),  64'd0);
      check("bp_hold_q",        64'(bus.q),         64'd142);
      check("bp_hold_m",        64'(bus.m),         64'd6);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready",  64'(bus.in_ready),  64'd1);
    check("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
    check("bp_queue_empty",       64'(sb.size()),     64'd0);

    // Reset in the middle of an operation.
    send("rst_mid", 1'b1, 32'd1000, 16'd7, 32'd142, 16'd6, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    #1;
    check("rst_mid_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_q",         64'(bus.q),         64'd0);
    check("rst_mid_m",         64'(bus.m),         64'd0);
    check("rst_mid_dz",        64'(bus.dz),        64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send("after_rst", 1'b1, 32'd100, 16'd10, 32'd10, 16'd0, 1'b0);
    wait_drain("after_rst");

    // Random regression with random result backpressure.
    for (int k = 0; k < 1000; k++) begin
      logic [31:0] rr;
      logic [15:0] vv;
      rr = $urandom;
      vv = (k % 4 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(1, 65535));
      send("random", 1'b0, rr, vv, 32'd0, 16'd0, 1'b0);
      begin
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 500) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
          guard++;
        end
      end
      wait_drain("random");
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
